// File: rtl/axi_slave_write_arbiter.sv
// Round-robin write-path arbiter sharing one AXI slave write port between NUM_MASTERS masters.
// A grant is held from AW arbitration until the owner's B handshake; one write outstanding per slave.
module axi_slave_write_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ID_W        = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [NUM_MASTERS*ID_W-1:0]       m_awid,
  input  logic [NUM_MASTERS*ADDR_W-1:0]     m_awaddr,
  input  logic [NUM_MASTERS*8-1:0]          m_awlen,
  input  logic [NUM_MASTERS*3-1:0]          m_awsize,
  input  logic [NUM_MASTERS*2-1:0]          m_awburst,
  input  logic [NUM_MASTERS-1:0]            m_awvalid,
  output logic [NUM_MASTERS-1:0]            m_awready,
  input  logic [NUM_MASTERS*DATA_W-1:0]     m_wdata,
  input  logic [NUM_MASTERS*(DATA_W/8)-1:0] m_wstrb,
  input  logic [NUM_MASTERS-1:0]            m_wlast,
  input  logic [NUM_MASTERS-1:0]            m_wvalid,
  output logic [NUM_MASTERS-1:0]            m_wready,
  output logic [ID_W-1:0]                   m_bid,
  output logic [1:0]                        m_bresp,
  output logic [NUM_MASTERS-1:0]            m_bvalid,
  input  logic [NUM_MASTERS-1:0]            m_bready,
  output logic [ID_W-1:0]                   s_awid,
  output logic [ADDR_W-1:0]                 s_awaddr,
  output logic [7:0]                        s_awlen,
  output logic [2:0]                        s_awsize,
  output logic [1:0]                        s_awburst,
  output logic                              s_awvalid,
  input  logic                              s_awready,
  output logic [DATA_W-1:0]                 s_wdata,
  output logic [DATA_W/8-1:0]               s_wstrb,
  output logic                              s_wlast,
  output logic                              s_wvalid,
  input  logic                              s_wready,
  input  logic [ID_W-1:0]                   s_bid,
  input  logic [1:0]                        s_bresp,
  input  logic                              s_bvalid,
  output logic                              s_bready,
  output logic [NUM_MASTERS-1:0]            grant
);
  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  // state | meaning
  // IDLE  | no owner; round-robin pick among m_awvalid
  // ADDR  | owner's AW forwarded to slave
  // DATA  | owner's W forwarded until wlast handshake
  // RESP  | slave B forwarded to owner; handshake frees the port
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]       last_grant_q, last_grant_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       pick_idx, cand;
  logic                   pick_found;

  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    cand       = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = IDX_W'((int'(last_grant_q) + k) % NUM_MASTERS);
      if (!pick_found && m_awvalid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    s_awid    = m_awid[ID_W-1:0];
    s_awaddr  = m_awaddr[ADDR_W-1:0];
    s_awlen   = m_awlen[7:0];
    s_awsize  = m_awsize[2:0];
    s_awburst = m_awburst[1:0];
    s_wdata   = m_wdata[DATA_W-1:0];
    s_wstrb   = m_wstrb[STRB_W-1:0];
    s_wlast   = m_wlast[0];
    for (int i = 1; i < NUM_MASTERS; i++) begin
      if (grant_idx_q == IDX_W'(i)) begin
        s_awid    = m_awid[i*ID_W +: ID_W];
        s_awaddr  = m_awaddr[i*ADDR_W +: ADDR_W];
        s_awlen   = m_awlen[i*8 +: 8];
        s_awsize  = m_awsize[i*3 +: 3];
        s_awburst = m_awburst[i*2 +: 2];
        s_wdata   = m_wdata[i*DATA_W +: DATA_W];
        s_wstrb   = m_wstrb[i*STRB_W +: STRB_W];
        s_wlast   = m_wlast[i];
      end
    end
    m_bid     = s_bid;
    m_bresp   = s_bresp;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    case (state_q)
      ADDR: begin
        s_awvalid              = m_awvalid[grant_idx_q];
        m_awready[grant_idx_q] = s_awready;
      end
      DATA: begin
        s_wvalid              = m_wvalid[grant_idx_q];
        m_wready[grant_idx_q] = s_wready;
      end
      RESP: begin
        s_bready              = m_bready[grant_idx_q];
        m_bvalid[grant_idx_q] = s_bvalid;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    case (state_q)
      IDLE: if (pick_found) begin
        grant_idx_d = pick_idx;
        grant_d     = NUM_MASTERS'(1) << pick_idx;
        state_d     = ADDR;
      end
      ADDR: if (s_awvalid && s_awready) state_d = DATA;
      DATA: if (s_wvalid && s_wready && s_wlast) state_d = RESP;
      RESP: if (s_bvalid && s_bready) begin
        last_grant_d = grant_idx_q;
        grant_d      = '0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      grant_idx_q  <= '0;
      last_grant_q <= IDX_W'(NUM_MASTERS - 1);
      grant_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
    end
  end

  assign grant = grant_q;
endmodule
